seven_segment_scan_decoder: RTL and testbench

- Decodes a multiplexed seven-segment display bus back into hex nibbles. Inputs are the segment lines plus a one-hot digit-enable scan.
- Used as a display read-back and self-check monitor alongside the core's display driver.
- Waits for each scanned digit to be stable, decodes its pattern, and stores it in a per-digit register file.
- Flags illegal patterns and reports completed scan frames.

---
 rtl/seven_segment_scan_decoder.sv | 256 +++++++++++++++++++++++++
 tb/tb_seven_segment_scan_decoder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_decoder.sv
// seven_segment_scan_decoder
//
// Read-back monitor for a multiplexed seven-segment display bus. Each scanned
// digit must hold one pattern for STABLE_CYCLES consecutive samples. The
// pattern is then decoded to a hex nibble and stored in a per-digit register.
// Illegal patterns are flagged. A pulse marks each frame in which every digit
// has been captured at least once.
//
// Parameters:
//   NUM_DIGITS     number of scanned digits (1..8)
//   STABLE_CYCLES  identical samples required before a capture (>=1)
//
// Optional build macro:
//   SEG_SYNC_EN    puts a 2-flop synchronizer on segments/digit_en ahead of
//                  the input stage. Every latency grows by 2 cycles.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   segments    segment lines a..g on bits 6..0, active-high
//   digit_en    one-hot digit enables, active-high
//   clear       synchronous clear of valid/err/seen; forces re-settle
//   digits      decoded nibbles, digit i at [4i+3:4i]
//   valid       digit i holds a legally decoded value
//   err         last capture of digit i was an illegal pattern
//   update      one-cycle pulse per capture
//   update_idx  index of the digit captured with update
//   frame_done  pulse on the capture that completes the seen mask
module seven_segment_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              segments,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   valid,
  output logic [NUM_DIGITS-1:0]   err,
  output logic                    update,
  output logic [IDX_W-1:0]        update_idx,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  // Returns {legal, nibble}.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h7E:   decode = {1'b1, 4'h0};
      7'h30:   decode = {1'b1, 4'h1};
      7'h6D:   decode = {1'b1, 4'h2};
      7'h79:   decode = {1'b1, 4'h3};
      7'h33:   decode = {1'b1, 4'h4};
      7'h5B:   decode = {1'b1, 4'h5};
      7'h5F:   decode = {1'b1, 4'h6};
      7'h70:   decode = {1'b1, 4'h7};
      7'h7F:   decode = {1'b1, 4'h8};
      7'h73:   decode = {1'b1, 4'h9};
      7'h77:   decode = {1'b1, 4'hA};
      7'h1F:   decode = {1'b1, 4'hB};
      7'h4E:   decode = {1'b1, 4'hC};
      7'h3D:   decode = {1'b1, 4'hD};
      7'h4F:   decode = {1'b1, 4'hE};
      7'h47:   decode = {1'b1, 4'hF};
      default: decode = 5'h00;
    endcase
  endfunction

  logic [6:0]            seg_in;
  logic [NUM_DIGITS-1:0] en_in;

`ifdef SEG_SYNC_EN
  logic [6:0]            seg_s1_reg, seg_s2_reg;
  logic [NUM_DIGITS-1:0] en_s1_reg, en_s2_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_reg <= '0;
      seg_s2_reg <= '0;
      en_s1_reg  <= '0;
      en_s2_reg  <= '0;
    end else begin
      seg_s1_reg <= segments;
      seg_s2_reg <= seg_s1_reg;
      en_s1_reg  <= digit_en;
      en_s2_reg  <= en_s1_reg;
    end
  end

  assign seg_in = seg_s2_reg;
  assign en_in  = en_s2_reg;
`else
  assign seg_in = segments;
  assign en_in  = digit_en;
`endif

  // Input stage plus a copy of the previous sample for the stability compare.
  logic [6:0]            seg_q, seg_p;
  logic [NUM_DIGITS-1:0] en_q, en_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '0;
      en_q  <= '0;
      seg_p <= '0;
      en_p  <= '0;
    end else begin
      seg_q <= seg_in;
      en_q  <= en_in;
      seg_p <= seg_q;
      en_p  <= en_q;
    end
  end

  logic one_hot, same;
  assign one_hot = (en_q != '0) && ((en_q & (en_q - 1'b1)) == '0);
  assign same    = one_hot && (seg_q == seg_p) && (en_q == en_p);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             capture;

  // The capture is taken on the same edge at which the count reaches
  // STABLE_CYCLES, so the update pulse is visible STABLE_CYCLES+1 cycles after
  // the pair first appears on the inputs.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (one_hot) begin
          state_next = SETTLE;
          cnt_next   = CNT_ONE;
        end
      end
      SETTLE: begin
        if (!one_hot) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (same) begin
          cnt_next = (cnt_reg == CNT_FULL) ? cnt_reg : cnt_reg + 1'b1;
        end else begin
          cnt_next = CNT_ONE;
        end
      end
      HOLD: begin
        if (!one_hot) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (!same) begin
          state_next = SETTLE;
          cnt_next   = CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    if (state_next == SETTLE && cnt_next == CNT_FULL) begin
      capture    = 1'b1;
      state_next = HOLD;
    end
  end

  logic [IDX_W-1:0] cap_idx;
  always_comb begin
    cap_idx = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (en_q[k]) cap_idx = IDX_W'(k);
    end
  end

  logic [NUM_DIGITS-1:0] seen_reg;
  logic                  update_reg, frame_done_reg;
  logic [IDX_W-1:0]      update_idx_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      seen_reg       <= '0;
      update_reg     <= 1'b0;
      update_idx_reg <= '0;
      frame_done_reg <= 1'b0;
    end else if (clear) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      seen_reg       <= '0;
      update_reg     <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      update_reg     <= capture;
      frame_done_reg <= 1'b0;
      if (capture) begin
        update_idx_reg <= cap_idx;
        // The completing digit is not carried into the next frame.
        if ((seen_reg | en_q) == '1) begin
          seen_reg       <= '0;
          frame_done_reg <= 1'b1;
        end else begin
          seen_reg <= seen_reg | en_q;
        end
      end
    end
  end

  assign update     = update_reg;
  assign update_idx = update_idx_reg;
  assign frame_done = frame_done_reg;

  logic [4:0] dec;
  assign dec = decode(seg_q);

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic [3:0] nib_reg;
    logic       valid_reg, err_reg;

    // An illegal pattern keeps the previous nibble and only flips the flags.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        nib_reg   <= '0;
        valid_reg <= 1'b0;
        err_reg   <= 1'b0;
      end else if (clear) begin
        valid_reg <= 1'b0;
        err_reg   <= 1'b0;
      end else if (capture && en_q[gi]) begin
        if (dec[4]) begin
          nib_reg   <= dec[3:0];
          valid_reg <= 1'b1;
          err_reg   <= 1'b0;
        end else begin
          valid_reg <= 1'b0;
          err_reg   <= 1'b1;
        end
      end
    end

    assign digits[4*gi +: 4] = nib_reg;
    assign valid[gi]         = valid_reg;
    assign err[gi]           = err_reg;
  end

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Testbench for seven_segment_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=4).
// Directed sequences and a decode table with hand-written expectations, plus
// randomized scans compared every cycle against a run-length reference model.
module tb_seven_segment_scan_decoder;
  localparam int N      = 4;
  localparam int STABLE = 4;
`ifdef SEG_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int LAT = STABLE + 1 + SYNC;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [6:0] segments = '0;
  logic [3:0] digit_en = '0;
  logic       clear    = 1'b0;
  logic [15:0] digits;
  logic [3:0]  valid, err;
  logic        update, frame_done;
  logic [1:0]  update_idx;

  seven_segment_scan_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .rst_n(rst_n), .segments(segments), .digit_en(digit_en),
    .clear(clear), .digits(digits), .valid(valid), .err(err),
    .update(update), .update_idx(update_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  logic [6:0] m_s1_seg, m_s2_seg, m_cur_seg;
  logic [3:0] m_s1_en, m_s2_en, m_cur_en;
  int         m_run;  // length of the run of identical one-hot samples ending at m_cur
  logic [3:0] m_nib [4];
  logic [3:0] m_valid, m_err, m_seen;
  logic       m_upd, m_fd;
  logic [1:0] m_idx;

  task automatic model_step();
    logic [6:0] nseg;
    logic [3:0] nen;
    int         idx;
    bit         legal;
    logic [3:0] val;
    if (!rst_n) begin
      m_s1_seg = 0; m_s2_seg = 0; m_cur_seg = 0;
      m_s1_en = 0; m_s2_en = 0; m_cur_en = 0;
      m_run = 0;
      for (int k = 0; k < 4; k++) m_nib[k] = 0;
      m_valid = 0; m_err = 0; m_seen = 0; m_upd = 0; m_fd = 0; m_idx = 0;
      return;
    end
    m_upd = 0;
    m_fd  = 0;
    if (clear) begin
      m_valid = 0; m_err = 0; m_seen = 0;
    end else if ($countones(m_cur_en) == 1 && m_run == STABLE) begin
      idx = 0;
      for (int k = 0; k < 4; k++) if (m_cur_en[k]) idx = k;
      legal = 0;
      val   = 0;
      for (int v = 0; v < 16; v++) if (seg_tab[v] == m_cur_seg) begin legal = 1; val = v[3:0]; end
      if (legal) begin m_nib[idx] = val; m_valid[idx] = 1; m_err[idx] = 0; end
      else       begin m_valid[idx] = 0; m_err[idx] = 1; end
      m_upd = 1;
      m_idx = idx[1:0];
      if ((m_seen | (4'b1 << idx)) == 4'hF) begin m_seen = 0; m_fd = 1; end
      else m_seen = m_seen | (4'b1 << idx);
    end
`ifdef SEG_SYNC_EN
    nseg = m_s2_seg; nen = m_s2_en;
    m_s2_seg = m_s1_seg; m_s2_en = m_s1_en;
    m_s1_seg = segments; m_s1_en = digit_en;
`else
    nseg = segments; nen = digit_en;
`endif
    if ($countones(nen) != 1) m_run = 0;
    else if (!clear && nseg == m_cur_seg && nen == m_cur_en) m_run = (m_run < STABLE + 1) ? m_run + 1 : m_run;
    else m_run = 1;
    m_cur_seg = nseg;
    m_cur_en  = nen;
  endtask

  // ---------------- cycle stepping ----------------
  int upd_cnt, fd_cnt, fd_at;

  task automatic clr_cnt();
    upd_cnt = 0; fd_cnt = 0; fd_at = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("scoreboard", {digits, valid, err, update, update_idx, frame_done},
          {m_nib[3], m_nib[2], m_nib[1], m_nib[0], m_valid, m_err, m_upd, m_idx, m_fd});
    if (update) upd_cnt++;
    if (frame_done) begin fd_cnt++; fd_at = upd_cnt; end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    logic [6:0] seg;
    logic [3:0] nib;
    logic       legal;
  } vec_t;

  vec_t       vecs [19];
  logic [6:0] scan_seg [4] = '{7'h30, 7'h6D, 7'h79, 7'h47};
  logic [3:0] scan_en  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    vecs = '{'{7'h7E, 4'h0, 1'b1}, '{7'h30, 4'h1, 1'b1}, '{7'h6D, 4'h2, 1'b1}, '{7'h79, 4'h3, 1'b1},
             '{7'h33, 4'h4, 1'b1}, '{7'h5B, 4'h5, 1'b1}, '{7'h5F, 4'h6, 1'b1}, '{7'h70, 4'h7, 1'b1},
             '{7'h7F, 4'h8, 1'b1}, '{7'h73, 4'h9, 1'b1}, '{7'h77, 4'hA, 1'b1}, '{7'h1F, 4'hB, 1'b1},
             '{7'h4E, 4'hC, 1'b1}, '{7'h3D, 4'hD, 1'b1}, '{7'h4F, 4'hE, 1'b1}, '{7'h47, 4'hF, 1'b1},
             '{7'h00, 4'hF, 1'b0}, '{7'h7D, 4'hF, 1'b0}, '{7'h12, 4'hF, 1'b0}};

    // Reset state
    rst_n = 0;
    run(2);
    check("reset_outputs", {digits, valid, err, update, update_idx, frame_done}, 32'h0);

    // First capture latency
    segments = 7'h7E; digit_en = 4'b0001; rst_n = 1;
    clr_cnt();
    run(LAT - 1);
    check("latency_early_update", upd_cnt, 0);
    tick();
    check("latency_update", update, 1);
    check("latency_idx", update_idx, 0);
    check("latency_digit0", digits[3:0], 4'h0);
    check("latency_valid", valid, 4'b0001);
    check("latency_err", err, 4'b0000);
    $display("txn latency: en=0001 seg=7E update at cycle %0d", LAT);

    // Full scan frame
    clr_cnt();
    for (int i = 0; i < 4; i++) begin
      segments = scan_seg[i]; digit_en = scan_en[i];
      run(8);
      $display("txn scan: en=%b seg=%h", scan_en[i], scan_seg[i]);
    end
    check("scan_updates", upd_cnt, 4);
    check("scan_frame_pulses", fd_cnt, 1);
    check("scan_frame_on_update", fd_at, 4);
    check("scan_digits", digits, 16'hF321);
    check("scan_valid", valid, 4'hF);

    // Illegal pattern on digit 1
    clr_cnt();
    segments = 7'h00; digit_en = 4'b0010;
    run(8);
    $display("txn illegal: en=0010 seg=00");
    check("illegal_err", err, 4'b0010);
    check("illegal_valid", valid, 4'b1101);
    check("illegal_digit1_kept", digits[7:4], 4'h2);
    check("illegal_updates", upd_cnt, 1);

    // Unstable and multi-hot inputs never capture
    clr_cnt();
    digit_en = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      segments = (i % 2 == 0) ? 7'h7E : 7'h30;
      run(2);
    end
    check("toggle_no_update", upd_cnt, 0);
    clr_cnt();
    digit_en = 4'b0011; segments = 7'h7E;
    run(10);
    check("multihot_no_update", upd_cnt, 0);
    $display("txn unstable: toggling and multi-hot scans");

    // Clear on the capture edge, then re-capture after the settle time
    segments = 7'h5B; digit_en = 4'b0100;
    clr_cnt();
    run(LAT - 1);
    check("clear_pre_update", upd_cnt, 0);
    clear = 1;
    tick();
    check("clear_blocks_update", update, 0);
    check("clear_valid", valid, 4'h0);
    check("clear_err", err, 4'h0);
    check("clear_no_frame", frame_done, 0);
    clear = 0;
    clr_cnt();
    run(STABLE - 1);
    check("clear_resettle_early", upd_cnt, 0);
    tick();
    check("clear_recapture", update, 1);
    check("clear_recapture_idx", update_idx, 2);
    check("clear_recapture_digit2", digits[11:8], 4'h5);
    $display("txn clear: en=0100 seg=5B recaptured");

    // Reset mid-settle
    segments = 7'h4E; digit_en = 4'b1000;
    run(2);
    rst_n = 0;
    #1;
    check("reset_async_outputs", {digits, valid, err, update, update_idx, frame_done}, 32'h0);
    run(2);
    rst_n = 1;
    clr_cnt();
    run(LAT - 1);
    check("reset_no_spurious_update", upd_cnt, 0);
    tick();
    check("reset_recapture", update, 1);
    check("reset_digits", digits, 16'hC000);
    check("reset_valid", valid, 4'b1000);
    $display("txn reset: en=1000 seg=4E captured after release");

    // Decode table on digit 3
    for (int i = 0; i < 19; i++) begin
      digit_en = 4'b0000;
      tick();
      segments = vecs[i].seg; digit_en = 4'b1000;
      clr_cnt();
      run(LAT + 1);
      $display("txn table %0d: seg=%h -> digit3=%h valid=%b err=%b", i, vecs[i].seg, digits[15:12], valid[3], err[3]);
      check("table_nibble", digits[15:12], vecs[i].nib);
      check("table_valid", valid[3], vecs[i].legal);
      check("table_err", err[3], !vecs[i].legal);
      check("table_updates", upd_cnt, 1);
    end

    // Randomized scans against the model
    for (int t = 0; t < 60; t++) begin
      int kind, hold;
      kind = $urandom_range(0, 9);
      hold = $urandom_range(1, 9);
      if (kind < 6) begin
        digit_en = 4'b1 << $urandom_range(0, 3);
        segments = seg_tab[$urandom_range(0, 15)];
      end else if (kind < 8) begin
        digit_en = 4'b1 << $urandom_range(0, 3);
        segments = 7'($urandom);
      end else if (kind == 8) begin
        digit_en = 4'($urandom);
      end
      $display("txn rand %0d: en=%b seg=%h hold=%0d", t, digit_en, segments, hold);
      for (int h = 0; h < hold; h++) begin
        clear = ($urandom_range(0, 11) == 0);
        tick();
      end
      clear = 0;
    end
    run(LAT + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
